grf_write_arbiter: RTL and testbench
====================================

// Module: grf_write_arbiter
//
// PURPOSE
// Shares the single GRF write port between the pipeline writeback stage and the
// multiply/divide unit (MDU), whose results return a variable number of cycles late.
// MDU results are buffered in a small FIFO. One write per cycle is granted, with
// priority to the pipeline and an anti-starvation limit. Outputs drive the GRF
// write port (we/addr/data/pc) through registers.
//
// PARAMETERS
// DEPTH       4  MDU result FIFO entries; power of two, >= 2
// STARVE_MAX  3  consecutive pipeline grants allowed while FIFO is non-empty
//
// PORTS
// clk         in   1   clock, all state updates on posedge
// reset       in   1   synchronous, active-high
// p_valid     in   1   pipeline WB has a write this cycle
// p_addr      in   5   pipeline destination register
// p_data      in   32  pipeline write data
// p_pc        in   32  PC of the pipeline instruction
// p_stall     out  1   pipeline WB not granted; hold p_* stable next cycle
// m_valid     in   1   MDU result valid
// m_ready     out  1   FIFO can accept (= !full)
// m_addr      in   5   MDU destination register
// m_data      in   32  MDU result
// m_pc        in   32  PC of the MDU instruction
// grf_we      out  1   GRF write enable (registered)
// grf_addr    out  5   GRF write address (registered)
// grf_data    out  32  GRF write data (registered)
// grf_pc      out  32  PC for the write trace (registered)
// fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy
//
// BEHAVIOUR
// - Reset: FIFO emptied, fifo_count=0, starve_cnt=0, grf_we=0, grf_addr=0,
//   grf_data=0, grf_pc=0. Any in-flight MDU result or pending write is lost.
// - Enqueue: m_valid && m_ready at posedge pushes {m_addr,m_data,m_pc}.
//   m_addr==0 results are accepted but not stored.
// - m_ready is combinational from the registered count; no enqueue when full,
//   even if a dequeue happens in the same cycle.
// - No bypass: an entry pushed at edge t is eligible for grant from cycle t+1.
// - Grant decision (combinational, per cycle):
//   - fifo_sel = !empty && (!p_valid || starve_cnt == STARVE_MAX).
//   - Otherwise the pipeline is selected if p_valid.
// - p_stall = p_valid && fifo_sel.
// - Latency: the granted write appears on grf_* at the next posedge (1 cycle).
//   - grf_we=1 only if a source was granted and its addr != 0.
//   - Otherwise grf_we=0 and addr/data/pc hold their previous values.
// - Pipeline write with p_addr==0 is granted (no stall) but produces grf_we=0.
// - FIFO head pops on the same posedge that registers its grant.
// - Push and pop in the same cycle (when not full) leave the count unchanged.
// - starve_cnt rules:
//   - +1 when the pipeline is granted while the FIFO is non-empty (saturates
//     at STARVE_MAX).
//   - Cleared to 0 when the FIFO is granted or the FIFO is empty.
// - FIFO pointers wrap modulo DEPTH; full when count==DEPTH; empty when count==0.
// - Ordering: MDU results leave in arrival order. No write-address hazard checking;
//   the issue logic prevents conflicting same-register writes.
//
// TESTING
// 1 Reset with m_valid=1 -> m_ready=1, fifo_count=0, grf_we=0 next cycle; no push.
// 2 p_valid=1 p_addr=5 p_data=0x1234 p_pc=0x3000, FIFO empty -> p_stall=0;
//   next cycle grf_we=1 addr=5 data=0x1234 pc=0x3000.
// 3 Push MDU {8,0xBEEF,0x3010} with p_valid held 1 -> 3 pipeline grants
//   (starve_cnt 1,2,3), then p_stall=1 for one cycle; FIFO write to $8 follows.
// 4 Push 5 MDU results with p_valid=1 continuously (DEPTH=4) -> m_ready=0 after 4,
//   count stays 4 until a FIFO grant; 5th accepted only once m_ready=1.
// 5 MDU result with m_addr=0 -> accepted, fifo_count unchanged, grf_we never set.
// 6 Assert reset with 3 FIFO entries and p_stall=1 -> next cycle count=0, p_stall=0,
//   grf_we=0; none of the 3 entries is ever written.

Source files
------------

// File: rtl/grf_write_arbiter.sv
// Arbitrates the single GRF write port between pipeline writeback and buffered
// MDU results; pipeline has priority, bounded by an anti-starvation counter.
module grf_write_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     p_valid,
  input  logic [4:0]               p_addr,
  input  logic [31:0]              p_data,
  input  logic [31:0]              p_pc,
  output logic                     p_stall,
  input  logic                     m_valid,
  output logic                     m_ready,
  input  logic [4:0]               m_addr,
  input  logic [31:0]              m_data,
  input  logic [31:0]              m_pc,
  output logic                     grf_we,
  output logic [4:0]               grf_addr,
  output logic [31:0]              grf_data,
  output logic [31:0]              grf_pc,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          grf_we_q, grf_we_d;
  logic [4:0]    grf_addr_q, grf_addr_d;
  logic [31:0]   grf_data_q, grf_data_d;
  logic [31:0]   grf_pc_q, grf_pc_d;

  logic   fifo_empty, fifo_full, fifo_sel, pipe_sel, push, pop;
  entry_t head;

  // Handshake: an MDU result transfers on any posedge where m_valid && m_ready;
  // m_ready depends only on registered occupancy, so a same-cycle pop never
  // opens room. A stalled pipeline (p_stall=1) must hold p_* for the next cycle.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign m_ready    = !fifo_full;
  assign fifo_sel   = !fifo_empty && (!p_valid || starve_q == STARVE_LIM);
  assign pipe_sel   = p_valid && !fifo_sel;
  assign p_stall    = p_valid && fifo_sel;
  // Writes to $0 are acknowledged but never occupy a FIFO slot.
  assign push       = m_valid && m_ready && (m_addr != 5'd0);
  assign pop        = fifo_sel;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    starve_d   = starve_q;
    grf_we_d   = 1'b0;
    grf_addr_d = grf_addr_q;
    grf_data_d = grf_data_q;
    grf_pc_d   = grf_pc_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{addr: m_addr, data: m_data, pc: m_pc};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (fifo_sel && head.addr != 5'd0) begin
      grf_we_d   = 1'b1;
      grf_addr_d = head.addr;
      grf_data_d = head.data;
      grf_pc_d   = head.pc;
    end else if (pipe_sel && p_addr != 5'd0) begin
      grf_we_d   = 1'b1;
      grf_addr_d = p_addr;
      grf_data_d = p_data;
      grf_pc_d   = p_pc;
    end

    if (fifo_empty || fifo_sel) starve_d = '0;
    else if (pipe_sel && starve_q != STARVE_LIM) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      grf_we_q   <= 1'b0;
      grf_addr_q <= '0;
      grf_data_q <= '0;
      grf_pc_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      grf_we_q   <= grf_we_d;
      grf_addr_q <= grf_addr_d;
      grf_data_q <= grf_data_d;
      grf_pc_q   <= grf_pc_d;
    end
  end

  // Storage needs no reset: pointers and count define which slots are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign grf_we     = grf_we_q;
  assign grf_addr   = grf_addr_q;
  assign grf_data   = grf_data_q;
  assign grf_pc     = grf_pc_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Directed bench for grf_write_arbiter: a queue-based reference model checked every
// cycle, plus hand-computed expectations at the key points of each scenario.
module tb_grf_write_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 3;

  logic        clk, reset;
  logic        p_valid, p_stall, m_valid, m_ready, grf_we;
  logic [4:0]  p_addr, m_addr, grf_addr;
  logic [31:0] p_data, p_pc, m_data, m_pc, grf_data, grf_pc;
  logic [2:0]  fifo_count;

  grf_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data), .p_pc(p_pc), .p_stall(p_stall),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data), .m_pc(m_pc),
    .grf_we(grf_we), .grf_addr(grf_addr), .grf_data(grf_data), .grf_pc(grf_pc),
    .fifo_count(fifo_count)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q holds pending MDU writes as {addr, data, pc} in arrival order.
  logic [68:0] exp_q[$];
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_gaddr;
  logic [31:0] m_gdata, m_gpc;
  bit          model_live = 0;

  always @(posedge clk) begin
    int          n;
    bit          fifo_g, pipe_g;
    logic [68:0] e;
    if (reset) begin
      exp_q.delete();
      m_starve   = 0;
      m_we       = 0;
      m_gaddr    = 0;
      m_gdata    = 0;
      m_gpc      = 0;
      model_live = 1;
    end else begin
      n      = exp_q.size();
      fifo_g = (n > 0) && (!p_valid || m_starve == STARVE_MAX);
      pipe_g = p_valid && !fifo_g;
      m_we   = 0;
      if (fifo_g) begin
        e = exp_q.pop_front();
        m_we = 1; m_gaddr = e[68:64]; m_gdata = e[63:32]; m_gpc = e[31:0];
      end else if (pipe_g && p_addr != 0) begin
        m_we = 1; m_gaddr = p_addr; m_gdata = p_data; m_gpc = p_pc;
      end
      if (n == 0 || fifo_g) m_starve = 0;
      else if (pipe_g && m_starve < STARVE_MAX) m_starve = m_starve + 1;
      if (m_valid && n < DEPTH && m_addr != 0) exp_q.push_back({m_addr, m_data, m_pc});
    end
  end

  // Every-cycle compare, on the falling edge.
  logic [4:0] log_addr[$];
  always @(negedge clk) begin
    if (model_live) begin
      chk("cyc_grf_we", grf_we, m_we);
      chk("cyc_grf_addr", grf_addr, m_gaddr);
      chk("cyc_grf_data", grf_data, m_gdata);
      chk("cyc_grf_pc", grf_pc, m_gpc);
      chk("cyc_fifo_count", fifo_count, exp_q.size());
      chk("cyc_m_ready", m_ready, exp_q.size() != DEPTH);
      chk("cyc_p_stall", p_stall, p_valid && exp_q.size() > 0 && m_starve == STARVE_MAX);
      if (grf_we) log_addr.push_back(grf_addr);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_p(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] pc);
    p_valid = v; p_addr = a; p_data = d; p_pc = pc;
  endtask

  task automatic drive_m(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] pc);
    m_valid = v; m_addr = a; m_data = d; m_pc = pc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int accepted;
    int mark;
    bit hit;
    reset = 1'b1;
    drive_p(0, 0, 0, 0);
    drive_m(1, 5'd7, 32'h7777, 32'h1000);

    // Reset while an MDU result is offered: nothing may be stored.
    step();
    step();
    chk("rst_m_ready", m_ready, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_grf_we", grf_we, 0);
    chk("rst_grf_addr", grf_addr, 0);
    reset = 1'b0;
    drive_m(0, 0, 0, 0);
    step();
    chk("post_rst_count", fifo_count, 0);

    // Plain pipeline write with an empty FIFO.
    drive_p(1, 5'd5, 32'h1234, 32'h3000);
    chk("p_nostall", p_stall, 0);
    step();
    drive_p(0, 0, 0, 0);
    chk("p_we", grf_we, 1);
    chk("p_addr", grf_addr, 5);
    chk("p_data", grf_data, 32'h1234);
    chk("p_pc", grf_pc, 32'h3000);
    step();
    chk("idle_we", grf_we, 0);
    chk("idle_hold_addr", grf_addr, 5);

    // Starvation limit: three pipeline grants, then one FIFO grant.
    drive_m(1, 5'd8, 32'hBEEF, 32'h3010);
    drive_p(1, 5'd9, 32'h9999, 32'h3004);
    step();
    drive_m(0, 0, 0, 0);
    chk("st_count1", fifo_count, 1);
    for (int i = 0; i < 3; i++) begin
      chk("st_nostall", p_stall, 0);
      step();
    end
    chk("st_stall", p_stall, 1);
    step();
    chk("st_fifo_we", grf_we, 1);
    chk("st_fifo_addr", grf_addr, 8);
    chk("st_fifo_data", grf_data, 32'hBEEF);
    chk("st_fifo_pc", grf_pc, 32'h3010);
    chk("st_count0", fifo_count, 0);
    chk("st_stall_clear", p_stall, 0);
    drive_p(0, 0, 0, 0);
    step();

    // Fill to DEPTH under continuous pipeline traffic; fifth waits for m_ready.
    drive_p(1, 5'd3, 32'h3333, 32'h4000);
    accepted = 0;
    for (int c = 0; c < 30 && accepted < 5; c++) begin
      drive_m(1, 5'(10 + accepted), 32'hA000 + accepted, 32'h5000 + 4 * accepted);
      if (accepted == 4 && c == 4) begin
        chk("full_m_ready", m_ready, 0);
        chk("full_count", fifo_count, 4);
      end
      if (m_ready) accepted++;
      step();
    end
    chk("fill_accepted", accepted, 5);
    drive_m(0, 0, 0, 0);
    drive_p(0, 0, 0, 0);
    mark = 0;
    for (int c = 0; c < 20 && fifo_count != 0; c++) begin
      step();
      mark++;
    end
    chk("drain_empty", fifo_count, 0);
    chk("drain_last_addr", grf_addr, 14);
    chk("drain_last_data", grf_data, 32'hA004);

    // MDU result to $0: accepted, not stored, never written.
    drive_m(1, 5'd0, 32'hDEAD, 32'h6000);
    chk("z_m_ready", m_ready, 1);
    step();
    drive_m(0, 0, 0, 0);
    chk("z_count", fifo_count, 0);
    chk("z_we", grf_we, 0);
    step();
    chk("z_we2", grf_we, 0);

    // Reset with three entries pending and the pipeline stalled.
    drive_p(1, 5'd4, 32'h4444, 32'h7000);
    for (int i = 0; i < 3; i++) begin
      drive_m(1, 5'(20 + i), 32'hC000 + i, 32'h7100 + 4 * i);
      step();
    end
    drive_m(0, 0, 0, 0);
    step();
    chk("r6_pre_count", fifo_count, 3);
    chk("r6_pre_stall", p_stall, 1);
    reset = 1'b1;
    step();
    chk("r6_count", fifo_count, 0);
    chk("r6_stall", p_stall, 0);
    chk("r6_we", grf_we, 0);
    reset = 1'b0;
    drive_p(0, 0, 0, 0);
    mark = log_addr.size();
    for (int i = 0; i < 6; i++) step();
    hit = 0;
    for (int i = mark; i < log_addr.size(); i++)
      if (log_addr[i] >= 20 && log_addr[i] <= 22) hit = 1;
    chk("r6_lost_entries", hit, 0);
    chk("r6_idle_count", fifo_count, 0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
